// File: rtl/hash_out_serializer_if.sv
// Core-to-host digest handoff: result load, accept/busy handshake and byte stream.
interface hash_out_serializer_if;
    logic         en_i;
    logic         res_v_i;
    logic [511:0] res_i;
    logic [5:0]   nn_i;
    logic         ready_o;
    logic         hash_v_o;
    logic [7:0]   hash_o;
    logic         hash_last_o;
    logic         drop_o;

    // master: compression core / host side driving results in and sinking bytes
    modport master (
        output en_i, res_v_i, res_i, nn_i,
        input  ready_o, hash_v_o, hash_o, hash_last_o, drop_o
    );

    modport slave (
        input  en_i, res_v_i, res_i, nn_i,
        output ready_o, hash_v_o, hash_o, hash_last_o, drop_o
    );
endinterface

// File: rtl/hash_out_serializer.sv
// Streams a finished BLAKE2b state out one byte per cycle, little-endian, nn bytes long.
module hash_out_serializer (
    input  logic                 clk,
    input  logic                 rst,
    hash_out_serializer_if.slave bus
);
    typedef enum logic {IDLE, SEND} state_t;

    state_t       state_q, state_d;
    logic [511:0] sh_q;
    logic [5:0]   nn_q;
    logic [5:0]   cnt_q;
    logic         accept, emit, last, collide;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // nn_q - 1 wraps to 63 when nn_q is 0, which yields the 64-byte digest
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        emit    = 1'b0;
        last    = 1'b0;
        collide = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.res_v_i) begin
                    accept  = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                collide = bus.res_v_i;
                if (bus.en_i) begin
                    emit = 1'b1;
                    if (cnt_q == nn_q - 6'd1) begin
                        last    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.ready_o = (state_q == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q  <= '0;
            nn_q  <= '0;
            cnt_q <= '0;
        end else if (accept) begin
            sh_q  <= bus.res_i;
            nn_q  <= bus.nn_i;
            cnt_q <= '0;
        end else if (emit) begin
            // wipe on the final byte so no digest residue stays in the register
            sh_q  <= last ? '0 : {8'h00, sh_q[511:8]};
            cnt_q <= cnt_q + 6'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.hash_v_o    <= 1'b0;
            bus.hash_o      <= 8'h00;
            bus.hash_last_o <= 1'b0;
            bus.drop_o      <= 1'b0;
        end else begin
            bus.hash_v_o    <= emit;
            bus.hash_last_o <= last;
            if (emit)    bus.hash_o <= sh_q[7:0];
            if (collide) bus.drop_o <= 1'b1;
        end
    end
endmodule

// File: tb/tb_hash_out_serializer.sv
// Random and directed stimulus against a byte-queue model of the digest stream.
module tb_hash_out_serializer;
    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_pass = 0;

    hash_out_serializer_if bus ();
    hash_out_serializer dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    endtask

    // model: queue of bytes still owed to the host; busy whenever it is non-empty
    logic [7:0] q[$];
    logic       exp_drop = 1'b0;
    logic [7:0] exp_hash = 8'h00;
    logic       emit_nxt = 1'b0;

    always @(negedge clk) begin
        logic       exp_last;
        logic       busy;
        int         n;
        if (rst) begin
            q.delete();
            exp_drop = 1'b0;
            exp_hash = 8'h00;
            emit_nxt = 1'b0;
            chk("rst_v",    bus.hash_v_o,    1'b0);
            chk("rst_hash", bus.hash_o,      8'h00);
            chk("rst_last", bus.hash_last_o, 1'b0);
            chk("rst_rdy",  bus.ready_o,     1'b1);
            chk("rst_drop", bus.drop_o,      1'b0);
        end else begin
            exp_last = 1'b0;
            chk("hash_v", bus.hash_v_o, emit_nxt);
            if (emit_nxt && q.size() > 0) begin
                exp_hash = q.pop_front();
                exp_last = (q.size() == 0);
            end
            chk("hash",  bus.hash_o,      exp_hash);
            chk("last",  bus.hash_last_o, exp_last);
            chk("ready", bus.ready_o,     q.size() == 0);
            chk("drop",  bus.drop_o,      exp_drop);
            busy     = (q.size() != 0);
            emit_nxt = busy && bus.en_i;
            if (bus.res_v_i) begin
                if (!busy) begin
                    n = (bus.nn_i == 6'd0) ? 64 : int'(bus.nn_i);
                    for (int k = 0; k < n; k++) q.push_back(bus.res_i[8*k +: 8]);
                end else begin
                    exp_drop = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [511:0] d, input logic [5:0] nn);
        bus.res_v_i = 1'b1;
        bus.res_i   = d;
        bus.nn_i    = nn;
        tick();
        bus.res_v_i = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int c = 0;
        while (!bus.ready_o && c < budget) begin
            tick();
            c++;
        end
        if (!bus.ready_o) chk("timeout_idle", 64'd0, 64'd1);
    endtask

    task automatic wait_byte(input logic [7:0] b, input int budget);
        int c = 0;
        bit hit = 1'b0;
        while (!hit && c < budget) begin
            tick();
            c++;
            hit = bus.hash_v_o && (bus.hash_o == b);
        end
        if (!hit) chk("timeout_byte", 64'd0, 64'd1);
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    initial begin
        logic [511:0] ramp, d;
        for (int k = 0; k < 64; k++) ramp[8*k +: 8] = 8'(k);
        rst         = 1'b1;
        bus.en_i    = 1'b1;
        bus.res_v_i = 1'b0;
        bus.res_i   = '0;
        bus.nn_i    = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // 32-byte ramp, then full 64-byte digest and register wipe
        pulse(ramp, 6'd32);
        wait_idle(100);
        tick();
        pulse(ramp, 6'd0);
        wait_idle(100);
        chk("sh_clear", 64'(|dut.sh_q), 64'd0);
        tick();

        // three-cycle enable stall after byte 0x05
        pulse(ramp, 6'd16);
        wait_byte(8'h05, 50);
        bus.en_i = 1'b0;
        repeat (3) tick();
        bus.en_i = 1'b1;
        wait_idle(50);
        tick();

        // collision while byte 0x08 is out
        pulse(ramp, 6'd32);
        wait_byte(8'h08, 50);
        pulse(~ramp, 6'd5);
        wait_idle(100);
        repeat (4) tick();

        // reset mid-burst, then a single-byte digest
        pulse(ramp, 6'd32);
        wait_byte(8'h0A, 50);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        d = rnd512();
        d[7:0] = 8'hA5;
        pulse(d, 6'd1);
        wait_idle(20);
        repeat (2) tick();

        // back-to-back single-byte digests, second pulsed as ready rises
        pulse(rnd512(), 6'd1);
        wait_idle(20);
        pulse(rnd512(), 6'd1);
        wait_idle(20);
        repeat (3) tick();

        // random traffic: enable gaps, random lengths, collisions
        for (int c = 0; c < 1500; c++) begin
            bus.en_i    = ($urandom_range(0, 9) != 0);
            bus.res_v_i = ($urandom_range(0, 19) == 0);
            bus.res_i   = rnd512();
            bus.nn_i    = 6'($urandom_range(0, 63));
            tick();
        end
        bus.res_v_i = 1'b0;
        bus.en_i    = 1'b1;
        wait_idle(200);
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
